sdfa_inf_serializer: RTL and testbench
======================================

# sdfa_inf_serializer

Bit-serial transmitter for the SDFA configuration side-channel. Accepts parallel master-information and block-information words from the host and shifts them out MSB-first on two independent serial lanes. The two lanes drive `master_in`/`master_inf_valid` and `block_in`/`block_inf_valid` of `sdfa_top_controller`. A frame starts when the controller raises `set_up_req`. The frame ends after a fixed number of words has been sent on each lane.

## Interface
- `MASTER_W`, default 29: master word width in bits.
- `BLOCK_W`, default 23: block word width in bits.
- `MASTER_WORDS`, default 7: master words per frame.
- `BLOCK_WORDS`, default 6: block words per frame.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `set_up_req` input 1: frame request from the controller.
- `master_wr_valid` input 1: host master word valid.
- `master_wr_data` input `MASTER_W`: host master word.
- `master_wr_ready` output 1: master word accepted when high together with `master_wr_valid`.
- `block_wr_valid` input 1: host block word valid.
- `block_wr_data` input `BLOCK_W`: host block word.
- `block_wr_ready` output 1: block word accepted when high together with `block_wr_valid`.
- `master_inf_valid` output 1: a serial master bit is present.
- `master_in` output 1: serial master bit.
- `block_inf_valid` output 1: a serial block bit is present.
- `block_in` output 1: serial block bit.
- `busy` output 1: a frame is in progress.
- `frame_done` output 1: one-cycle pulse when both lanes have finished.

## Operation
- Top FSM states: IDLE, STREAM, DONE.
  - IDLE → STREAM on a rising edge of `set_up_req`, detected with a registered copy of `set_up_req`.
  - `set_up_req` is ignored outside IDLE.
  - STREAM → DONE when both lanes report their word count is exhausted and their shifters are empty.
  - DONE lasts exactly one cycle. It asserts `frame_done` and returns to IDLE.
- `busy` = state is STREAM or DONE.
- Each lane has a `W`-bit shifter, a bit counter (`$clog2(W)` bits) and a word counter (`$clog2(WORDS+1)` bits). The word counter is cleared on IDLE → STREAM.
- Lane `wr_ready` = STREAM & (word count < WORDS) & (shifter empty | shifter on its last bit).
- On acceptance the lane loads the word and sets bit index to W-1. It then outputs bit W-1 down to bit 0, one bit per cycle.
- The lane's `inf_valid` is high exactly while a bit is being presented.
- If the host has no word ready, the lane idles: `inf_valid`=0 and the serial bit = 0. The gap lasts until the next acceptance.
- The serial bit is forced to 0 whenever `inf_valid`=0.
- The two lanes are independent. The block lane typically finishes first and then holds `block_inf_valid`=0.

## Timing
- Reset value of every output is 0. All internal state clears asynchronously on `rst`.
- Reset mid-frame aborts the frame immediately; no `frame_done` is produced.
- Acceptance at edge k → MSB visible with `inf_valid`=1 during cycle k+1.
- Words are sent back-to-back without gaps when the host keeps `wr_valid` high: acceptance occurs on the edge that retires the last bit.
- Minimum frame length is max(MASTER_W·MASTER_WORDS, BLOCK_W·BLOCK_WORDS) + 2 cycles after the `set_up_req` rising edge.
- `frame_done` fires on the cycle after the last bit of the slower lane.
- `set_up_req` that rises in the same cycle as DONE is ignored. A new frame needs a fresh rising edge seen in IDLE.
- All outputs are registered; there is no combinational path from the host inputs to the serial outputs. Exception: `wr_ready` is combinational from state only.

## Structure
- Shared package holds:
  - the FSM state encoding (IDLE=2'd0, STREAM=2'd1, DONE=2'd2);
  - default widths 29/23, matching `sdfa_top_controller`.
- One sub-module, `sdfa_inf_ser_lane`, parameterized by W and WORDS. It contains the shifter, counters and ready logic, and exports `lane_done`. The top instantiates it twice and holds the FSM and edge detect.

## Test plan
- Reset → `master_in`=`block_in`=`master_inf_valid`=`block_inf_valid`=`busy`=`frame_done`=0 → `set_up_req` rise with host always valid → 203 consecutive master bits and 138 consecutive block bits, MSB first, matching the words → `frame_done` pulse the cycle after master bit 203.
- Master word 29'h1ABCDEF0 → serial stream 1,1,0,1,0,1,0,1,1,1,1,0,0,1,1,0,1,1,1,1,0,1,1,1,1,0,0,0,0.
- Block host drops `wr_valid` for 5 cycles after word 2 → `block_inf_valid` low for exactly 5 cycles, `block_in`=0 throughout, then stream resumes with word 3 intact.
- `set_up_req` toggled during STREAM → no restart, word counts unchanged. Second rising edge after IDLE → a new full frame.
- `rst` asserted at master bit 100 → all outputs 0 asynchronously, no `frame_done`. Next `set_up_req` → complete frame from word 0.
- `MASTER_WORDS`=1, `BLOCK_WORDS`=1 → 29-bit and 23-bit bursts; `frame_done` 31 cycles after the rising edge of `set_up_req`.

Source files
------------

// File: rtl/sdfa_inf_serializer_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : sdfa_inf_serializer_pkg                                         |
// | Brief    : Shared FSM encoding, default widths and counter-width helper.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package sdfa_inf_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Word widths must match what sdfa_top_controller deserializes.
    localparam int c_master_w     = 29;
    localparam int c_block_w      = 23;
    localparam int c_master_words = 7;
    localparam int c_block_words  = 6;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sdfa_inf_ser_lane.sv
// +----------------------------------------------------------------------------+
// | Module   : sdfa_inf_ser_lane                                               |
// | Brief    : One MSB-first serial lane: shifter, bit/word counters, ready.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module sdfa_inf_ser_lane
    import sdfa_inf_serializer_pkg::*;
#(
    parameter int W     = c_master_w,
    parameter int WORDS = c_master_words
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic         i_stream,
    input  logic         i_wr_valid,
    input  logic [W-1:0] i_wr_data,
    output logic         o_wr_ready,
    output logic         o_inf_valid,
    output logic         o_ser_bit,
    output logic         o_lane_done
);

    localparam int BIT_CW  = cnt_width(W);
    localparam int WORD_CW = cnt_width(WORDS + 1);

    localparam logic [BIT_CW-1:0]  c_msb_idx = BIT_CW'(W - 1);
    localparam logic [WORD_CW-1:0] c_words   = WORD_CW'(WORDS);

    logic [W-1:0]       r_shift;
    logic [BIT_CW-1:0]  r_bit_idx;
    logic               r_active;
    logic [WORD_CW-1:0] r_word_cnt;

    logic w_last_bit;
    logic w_accept;
    logic w_words_left;

    assign w_last_bit   = r_active && (r_bit_idx == '0);
    assign w_words_left = (r_word_cnt < c_words);
    assign o_wr_ready   = i_stream && w_words_left && (!r_active || w_last_bit);
    assign w_accept     = o_wr_ready && i_wr_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_active   <= 1'b0;
            r_word_cnt <= '0;
        end else if (i_start) begin
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_active   <= 1'b0;
            r_word_cnt <= '0;
        end else if (w_accept) begin
            r_shift    <= i_wr_data;
            r_bit_idx  <= c_msb_idx;
            r_active   <= 1'b1;
            r_word_cnt <= r_word_cnt + WORD_CW'(1);
        end else if (w_last_bit) begin
            // Clearing the shifter keeps the serial bit at 0 during gaps.
            r_shift    <= '0;
            r_active   <= 1'b0;
        end else if (r_active) begin
            r_shift    <= {r_shift[W-2:0], 1'b0};
            r_bit_idx  <= r_bit_idx - BIT_CW'(1);
        end
    end

    assign o_inf_valid = r_active;
    assign o_ser_bit   = r_shift[W-1];

    // Asserted already during the final bit, so the frame FSM can enter DONE
    // on the very edge that retires it.
    assign o_lane_done = !w_words_left && (!r_active || w_last_bit);

endmodule

`default_nettype wire

// File: rtl/sdfa_inf_serializer.sv
// +----------------------------------------------------------------------------+
// | Module   : sdfa_inf_serializer                                             |
// | Brief    : Two-lane bit-serial transmitter for the SDFA config channel.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module sdfa_inf_serializer
    import sdfa_inf_serializer_pkg::*;
#(
    parameter int MASTER_W     = c_master_w,
    parameter int BLOCK_W      = c_block_w,
    parameter int MASTER_WORDS = c_master_words,
    parameter int BLOCK_WORDS  = c_block_words
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                set_up_req,
    input  logic                master_wr_valid,
    input  logic [MASTER_W-1:0] master_wr_data,
    output logic                master_wr_ready,
    input  logic                block_wr_valid,
    input  logic [BLOCK_W-1:0]  block_wr_data,
    output logic                block_wr_ready,
    output logic                master_inf_valid,
    output logic                master_in,
    output logic                block_inf_valid,
    output logic                block_in,
    output logic                busy,
    output logic                frame_done
);

    state_t r_state;
    state_t w_state_nxt;

    logic r_req_q;
    logic r_busy;
    logic r_frame_done;
    logic w_rise;
    logic w_start;
    logic w_stream;
    logic w_master_done;
    logic w_block_done;

    assign w_rise   = set_up_req && !r_req_q;
    assign w_stream = (r_state == STREAM);

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_state_nxt = STREAM;
                    w_start     = 1'b1;
                end
            end
            STREAM: begin
                if (w_master_done && w_block_done) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // busy/frame_done are registered off the next state so they line up with r_state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_req_q      <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_req_q      <= set_up_req;
            r_busy       <= (w_state_nxt != IDLE);
            r_frame_done <= (w_state_nxt == DONE);
        end
    end

    assign busy       = r_busy;
    assign frame_done = r_frame_done;

    sdfa_inf_ser_lane #(
        .W     (MASTER_W),
        .WORDS (MASTER_WORDS)
    ) u_master_lane (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_start),
        .i_stream    (w_stream),
        .i_wr_valid  (master_wr_valid),
        .i_wr_data   (master_wr_data),
        .o_wr_ready  (master_wr_ready),
        .o_inf_valid (master_inf_valid),
        .o_ser_bit   (master_in),
        .o_lane_done (w_master_done)
    );

    sdfa_inf_ser_lane #(
        .W     (BLOCK_W),
        .WORDS (BLOCK_WORDS)
    ) u_block_lane (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_start),
        .i_stream    (w_stream),
        .i_wr_valid  (block_wr_valid),
        .i_wr_data   (block_wr_data),
        .o_wr_ready  (block_wr_ready),
        .o_inf_valid (block_inf_valid),
        .o_ser_bit   (block_in),
        .o_lane_done (w_block_done)
    );

endmodule

`default_nettype wire

// File: tb/tb_sdfa_inf_serializer.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_sdfa_inf_serializer                                          |
// | Brief    : Self-checking bench: random words against a bit-timeline model. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_sdfa_inf_serializer;

    localparam int MW   = 29;
    localparam int BW   = 23;
    localparam int MN   = 7;
    localparam int BN   = 6;
    localparam int MAXC = 400;

    logic          clk = 1'b0;
    logic          rst;
    logic          set_up_req;
    logic          master_wr_valid;
    logic [MW-1:0] master_wr_data;
    logic          master_wr_ready;
    logic          block_wr_valid;
    logic [BW-1:0] block_wr_data;
    logic          block_wr_ready;
    logic          master_inf_valid;
    logic          master_in;
    logic          block_inf_valid;
    logic          block_in;
    logic          busy;
    logic          frame_done;

    logic          s1_req;
    logic [MW-1:0] s1_m_data;
    logic [BW-1:0] s1_b_data;
    logic          s1_m_ready;
    logic          s1_b_ready;
    logic          s1_miv;
    logic          s1_mi;
    logic          s1_biv;
    logic          s1_bi;
    logic          s1_busy;
    logic          s1_fd;

    int n_tests = 0;
    int n_fail  = 0;

    logic [MW-1:0] m_words [MN];
    logic [BW-1:0] b_words [BN];
    logic [5:0]    exp_vec [MAXC];

    always #5 clk = ~clk;

    sdfa_inf_serializer dut (
        .clk              (clk),
        .rst              (rst),
        .set_up_req       (set_up_req),
        .master_wr_valid  (master_wr_valid),
        .master_wr_data   (master_wr_data),
        .master_wr_ready  (master_wr_ready),
        .block_wr_valid   (block_wr_valid),
        .block_wr_data    (block_wr_data),
        .block_wr_ready   (block_wr_ready),
        .master_inf_valid (master_inf_valid),
        .master_in        (master_in),
        .block_inf_valid  (block_inf_valid),
        .block_in         (block_in),
        .busy             (busy),
        .frame_done       (frame_done)
    );

    sdfa_inf_serializer #(
        .MASTER_WORDS (1),
        .BLOCK_WORDS  (1)
    ) dut1 (
        .clk              (clk),
        .rst              (rst),
        .set_up_req       (s1_req),
        .master_wr_valid  (1'b1),
        .master_wr_data   (s1_m_data),
        .master_wr_ready  (s1_m_ready),
        .block_wr_valid   (1'b1),
        .block_wr_data    (s1_b_data),
        .block_wr_ready   (s1_b_ready),
        .master_inf_valid (s1_miv),
        .master_in        (s1_mi),
        .block_inf_valid  (s1_biv),
        .block_in         (s1_bi),
        .busy             (s1_busy),
        .frame_done       (s1_fd)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected per-cycle {mv, mb, bv, bb, frame_done, busy}, cycle 0 = edge that sees the request rise.
    task automatic build_model(input int gap_len, output int done_cyc);
        int cyc;
        int last_m;
        int last_b;
        for (int c = 0; c < MAXC; c++) exp_vec[c] = '0;
        for (int k = 0; k < MN * MW; k++) begin
            cyc = 1 + k;
            exp_vec[cyc][5] = 1'b1;
            exp_vec[cyc][4] = m_words[k / MW][MW - 1 - (k % MW)];
        end
        for (int k = 0; k < BN * BW; k++) begin
            cyc = 1 + k + ((k >= 3 * BW) ? gap_len : 0);
            exp_vec[cyc][3] = 1'b1;
            exp_vec[cyc][2] = b_words[k / BW][BW - 1 - (k % BW)];
        end
        last_m   = MN * MW;
        last_b   = BN * BW + gap_len;
        done_cyc = ((last_m > last_b) ? last_m : last_b) + 1;
        exp_vec[done_cyc][1] = 1'b1;
        for (int c = 0; c <= done_cyc; c++) exp_vec[c][0] = 1'b1;
    endtask

    task automatic run_frame(input string name, input int gap_len, input bit toggle,
                             input bit req_in_done, input int rst_cycle, input bit fixed_first);
        int            done_cyc;
        int            ncyc;
        int            m_idx;
        int            b_idx;
        int            stall_left;
        int            cap_n;
        bit            hs_m;
        bit            hs_b;
        bit            aborted;
        logic [MW-1:0] cap;
        logic [MW-1:0] spec_bits;

        for (int i = 0; i < MN; i++) m_words[i] = MW'($urandom);
        for (int i = 0; i < BN; i++) b_words[i] = BW'($urandom);
        if (fixed_first) m_words[0] = 29'h1ABCDEF0;
        build_model(gap_len, done_cyc);
        ncyc = done_cyc + 6;

        @(negedge clk);
        set_up_req = 1'b0;
        @(negedge clk);
        set_up_req      = 1'b1;
        m_idx           = 0;
        b_idx           = 0;
        stall_left      = 0;
        cap_n           = 0;
        cap             = '0;
        aborted         = 1'b0;
        master_wr_valid = 1'b1;
        master_wr_data  = m_words[0];
        block_wr_valid  = 1'b1;
        block_wr_data   = b_words[0];

        for (int c = 0; c < ncyc && !aborted; c++) begin
            hs_m = master_wr_valid && master_wr_ready;
            hs_b = block_wr_valid && block_wr_ready;
            @(posedge clk);
            @(negedge clk);
            if (hs_m) m_idx++;
            if (hs_b) begin
                b_idx++;
                if (b_idx == 3) stall_left = gap_len;
            end

            chk($sformatf("%s cycle %0d {mv,mb,bv,bb,fd,busy}", name, c),
                64'({master_inf_valid, master_in, block_inf_valid, block_in, frame_done, busy}),
                64'(exp_vec[c]));
            if (master_inf_valid && cap_n < MW) begin
                cap = {cap[MW-2:0], master_in};
                cap_n++;
            end

            if (c == 3) set_up_req = 1'b0;
            if (toggle && c >= 20 && c <= 40 && (c % 4) == 0) set_up_req = ~set_up_req;
            if (req_in_done && c == done_cyc) set_up_req = 1'b1;

            master_wr_valid = (m_idx < MN);
            master_wr_data  = (m_idx < MN) ? m_words[m_idx] : '0;
            if (stall_left > 0 && block_wr_ready) begin
                block_wr_valid = 1'b0;
                stall_left--;
            end else begin
                block_wr_valid = (b_idx < BN);
            end
            block_wr_data = (b_idx < BN) ? b_words[b_idx] : '0;

            if (c == rst_cycle) begin
                #1 rst = 1'b1;
                #1 chk($sformatf("%s async reset outputs", name),
                       64'({master_inf_valid, master_in, block_inf_valid, block_in, frame_done,
                            busy, master_wr_ready, block_wr_ready}), 64'(0));
                master_wr_valid = 1'b0;
                block_wr_valid  = 1'b0;
                set_up_req      = 1'b0;
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                for (int j = 0; j < 8; j++) begin
                    @(negedge clk);
                    chk($sformatf("%s post-reset idle %0d", name, j),
                        64'({master_inf_valid, block_inf_valid, frame_done, busy}), 64'(0));
                end
                aborted = 1'b1;
            end
        end

        master_wr_valid = 1'b0;
        block_wr_valid  = 1'b0;
        if (!aborted) begin
            chk($sformatf("%s master words sent", name), 64'(m_idx), 64'(MN));
            chk($sformatf("%s block words sent", name), 64'(b_idx), 64'(BN));
        end
        if (fixed_first) begin
            spec_bits = 29'b1_1010_1011_1100_1101_1110_1111_0000;
            chk("first master word serial stream", 64'(cap), 64'(spec_bits));
        end
    endtask

    task automatic run_short_frame();
        logic [5:0] e;
        int         busy_cnt;
        int         last;
        busy_cnt  = 0;
        s1_m_data = MW'($urandom);
        s1_b_data = BW'($urandom);
        last      = (MW > BW) ? MW : BW;
        @(negedge clk);
        s1_req = 1'b1;
        for (int c = 0; c < last + 8; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 3) s1_req = 1'b0;
            e[5] = (c >= 1 && c <= MW);
            e[4] = (c >= 1 && c <= MW) ? s1_m_data[MW - c] : 1'b0;
            e[3] = (c >= 1 && c <= BW);
            e[2] = (c >= 1 && c <= BW) ? s1_b_data[BW - c] : 1'b0;
            e[1] = (c == last + 1);
            e[0] = (c <= last + 1);
            chk($sformatf("short frame cycle %0d {mv,mb,bv,bb,fd,busy}", c),
                64'({s1_miv, s1_mi, s1_biv, s1_bi, s1_fd, s1_busy}), 64'(e));
            if (s1_busy) busy_cnt++;
        end
        chk("short frame length in cycles", 64'(busy_cnt), 64'(last + 2));
    endtask

    initial begin
        rst             = 1'b1;
        set_up_req      = 1'b0;
        master_wr_valid = 1'b0;
        master_wr_data  = '0;
        block_wr_valid  = 1'b0;
        block_wr_data   = '0;
        s1_req          = 1'b0;
        s1_m_data       = '0;
        s1_b_data       = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset outputs",
            64'({master_inf_valid, master_in, block_inf_valid, block_in, busy, frame_done,
                 master_wr_ready, block_wr_ready, s1_miv, s1_mi, s1_biv, s1_bi, s1_busy, s1_fd}),
            64'(0));
        rst = 1'b0;

        run_frame("basic",       0, 1'b0, 1'b0, -1,  1'b1);
        run_frame("gap+toggle",  5, 1'b1, 1'b1, -1,  1'b0);
        run_frame("reset@100",   0, 1'b0, 1'b0, 100, 1'b0);
        run_frame("after-reset", 0, 1'b0, 1'b0, -1,  1'b0);
        run_short_frame();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
